// File: rtl/game_pkg.sv
// Shared state encodings and winner codes for the match sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_LEFT  = 2'b01;
  localparam logic [1:0] W_RIGHT = 2'b10;

endpackage

// File: rtl/frame_timer.sv
// Counts frame ticks while enabled; done pulses on the tick that arrives at the terminal count.
module frame_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && tick && (cnt_q == term);
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && tick)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// Match-level sequencer: serve/play/pause/point/over flow, scoring, speed-up and winner.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int SPEEDUP_HITS = 4,
  parameter int HIT_W        = 3
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic               frame_tick,
  input  logic               start_p,
  input  logic               pause_p,
  input  logic               hit_p,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               guiwei,
  output logic               ball_en,
  output logic               s,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         winner,
  output logic [2:0]         state_o
);

  localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [HIT_W-1:0]   HIT_MAX = HIT_W'(SPEEDUP_HITS);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic               s_q, s_d, guiwei_q, guiwei_d, ball_en_q, ball_en_d;

  logic               timer_en, timer_clr, timer_done;
  logic [FRAME_W-1:0] timer_term;

  // One timer serves both SERVE and POINT; every state change restarts it.
  assign timer_en   = (state_q == ST_SERVE) || (state_q == ST_POINT);
  assign timer_term = (state_q == ST_SERVE) ? FRAME_W'(SERVE_FRAMES - 1)
                                            : FRAME_W'(POINT_FRAMES - 1);
  assign timer_clr  = (state_d != state_q);

  frame_timer #(.W(FRAME_W)) u_frame_timer (
    .clk  (vga_clk),
    .srst (sys_rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tick (frame_tick),
    .term (timer_term),
    .done (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    hit_d     = hit_q;
    s_d       = s_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_p) begin
          state_d   = ST_SERVE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = W_NONE;
          hit_d     = '0;
          s_d       = 1'b0;
        end
      end
      ST_SERVE: begin
        if (timer_done)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        s_d = (hit_q == HIT_MAX);
        if (hit_p && (hit_q != HIT_MAX))
          hit_d = hit_q + 1'b1;
        // Misses outrank hits and pause; a double miss replays the rally.
        if (miss_l && miss_r) begin
          state_d = ST_POINT;
        end else if (miss_l) begin
          score_r_d = score_r_q + 1'b1;
          if (score_r_d == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = W_RIGHT;
          end else begin
            state_d = ST_POINT;
          end
        end else if (miss_r) begin
          score_l_d = score_l_q + 1'b1;
          if (score_l_d == WIN_S) begin
            state_d  = ST_OVER;
            winner_d = W_LEFT;
          end else begin
            state_d = ST_POINT;
          end
        end else if (pause_p) begin
          state_d = ST_PAUSE;
        end
        if (miss_l || miss_r) begin
          hit_d = '0;
          s_d   = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (pause_p)
          state_d = ST_PLAY;
      end
      ST_POINT: begin
        if (timer_done)
          state_d = ST_SERVE;
      end
      default: begin
        state_d = ST_IDLE;
        hit_d   = '0;
        s_d     = 1'b0;
      end
    endcase

    guiwei_d  = !((state_d == ST_PLAY) || (state_d == ST_PAUSE));
    ball_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= W_NONE;
      hit_q     <= '0;
      s_q       <= 1'b0;
      guiwei_q  <= 1'b1;
      ball_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      hit_q     <= hit_d;
      s_q       <= s_d;
      guiwei_q  <= guiwei_d;
      ball_en_q <= ball_en_d;
    end
  end

  assign guiwei  = guiwei_q;
  assign ball_en = ball_en_q;
  assign s       = s_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign winner  = winner_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl; expectations are queued and checked at the falling edge.
module tb_game_ctrl;

  logic       vga_clk = 1'b0;
  logic       sys_rst, frame_tick, start_p, pause_p, hit_p, miss_l, miss_r;
  logic       guiwei, ball_en, s;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state_o;

  typedef struct packed {
    int         id;
    logic [2:0] st;
    logic       g;
    logic       b;
    logic       sp;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_push = 0;

  always #5 vga_clk = ~vga_clk;

  game_ctrl #(
    .WIN_SCORE(3), .SCORE_W(4), .SERVE_FRAMES(3),
    .POINT_FRAMES(2), .SPEEDUP_HITS(2), .HIT_W(3)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .frame_tick(frame_tick),
    .start_p(start_p), .pause_p(pause_p), .hit_p(hit_p),
    .miss_l(miss_l), .miss_r(miss_r),
    .guiwei(guiwei), .ball_en(ball_en), .s(s),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state_o(state_o)
  );

  // Monitor: pops every queued expectation and compares against the settled outputs.
  always @(negedge vga_clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (state_o !== e.st || guiwei !== e.g || ball_en !== e.b || s !== e.sp ||
          score_l !== e.sl || score_r !== e.sr || winner !== e.w) begin
        n_fail++;
        $display("FAIL vec%0d: got st=%0d g=%0b b=%0b s=%0b sl=%0d sr=%0d w=%0b, want st=%0d g=%0b b=%0b s=%0b sl=%0d sr=%0d w=%0b",
                 e.id, state_o, guiwei, ball_en, s, score_l, score_r, winner,
                 e.st, e.g, e.b, e.sp, e.sl, e.sr, e.w);
      end else begin
        $display("vec%0d ok: st=%0d g=%0b b=%0b s=%0b sl=%0d sr=%0d w=%0b",
                 e.id, state_o, guiwei, ball_en, s, score_l, score_r, winner);
      end
    end
  end

  task automatic chk(input int st, input int g, input int b, input int sp,
                     input int sl, input int sr, input int w);
    exp_t e;
    e.id = n_push; e.st = 3'(st); e.g = 1'(g); e.b = 1'(b); e.sp = 1'(sp);
    e.sl = 4'(sl); e.sr = 4'(sr); e.w = 2'(w);
    n_push++;
    exp_q.push_back(e);
  endtask

  // One clock cycle with the given pulses: start, pause, hit, miss_l, miss_r, frame_tick.
  task automatic cyc(input logic st, input logic pa, input logic hi,
                     input logic ml, input logic mr, input logic ft);
    start_p = st; pause_p = pa; hit_p = hi; miss_l = ml; miss_r = mr; frame_tick = ft;
    @(posedge vga_clk);
    #1;
    start_p = 0; pause_p = 0; hit_p = 0; miss_l = 0; miss_r = 0; frame_tick = 0;
  endtask

  task automatic point_to_serve(input int sl, input int sr);
    cyc(0, 0, 0, 0, 0, 1); chk(4, 1, 0, 0, sl, sr, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(1, 1, 0, 0, sl, sr, 0);
  endtask

  task automatic serve_to_play(input int sl, input int sr);
    cyc(0, 0, 0, 0, 0, 1); chk(1, 1, 0, 0, sl, sr, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(1, 1, 0, 0, sl, sr, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(2, 0, 1, 0, sl, sr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, required completion");
    $fatal(1);
  end

  initial begin
    sys_rst = 1; start_p = 0; pause_p = 0; hit_p = 0; miss_l = 0; miss_r = 0; frame_tick = 0;
    @(posedge vga_clk); #1;
    chk(0, 1, 0, 0, 0, 0, 0);
    sys_rst = 0;

    // 1: idle ignores ticks, start -> SERVE, 3 ticks (with a gap) -> PLAY
    cyc(0, 0, 0, 0, 0, 1); chk(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); chk(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1); chk(2, 0, 1, 0, 0, 0, 0);

    // 2: two hits -> s, start ignored in PLAY, miss_r scores left
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); chk(2, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0); chk(4, 1, 0, 0, 1, 0, 0);
    point_to_serve(1, 0);
    serve_to_play(1, 0);

    // 3: double miss replays the rally
    cyc(0, 0, 0, 1, 1, 0); chk(4, 1, 0, 0, 1, 0, 0);
    point_to_serve(1, 0);
    serve_to_play(1, 0);

    // 4: right wins 3-1; miss+hit and miss+pause both resolve to the miss
    cyc(0, 0, 1, 1, 0, 0); chk(4, 1, 0, 0, 1, 1, 0);
    point_to_serve(1, 1);
    serve_to_play(1, 1);
    cyc(0, 1, 0, 1, 0, 0); chk(4, 1, 0, 0, 1, 2, 0);
    point_to_serve(1, 2);
    serve_to_play(1, 2);
    cyc(0, 0, 0, 1, 0, 0); chk(5, 1, 0, 0, 1, 3, 2);
    cyc(0, 0, 0, 1, 0, 0); chk(5, 1, 0, 0, 1, 3, 2);
    cyc(0, 1, 0, 0, 1, 1); chk(5, 1, 0, 0, 1, 3, 2);
    cyc(1, 0, 0, 0, 0, 0); chk(1, 1, 0, 0, 0, 0, 0);
    serve_to_play(0, 0);

    // 5: pause holds s, ignores miss/hit, resumes
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk(2, 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); chk(3, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 1); chk(3, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); chk(2, 0, 1, 1, 0, 0, 0);

    // 6: reach score_l=2 with s=1, then reset mid-rally
    cyc(0, 0, 0, 0, 1, 0); chk(4, 1, 0, 0, 1, 0, 0);
    point_to_serve(1, 0);
    serve_to_play(1, 0);
    cyc(0, 0, 0, 0, 1, 0); chk(4, 1, 0, 0, 2, 0, 0);
    point_to_serve(2, 0);
    serve_to_play(2, 0);
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 2, 0, 0);
    cyc(0, 0, 1, 0, 0, 0); chk(2, 0, 1, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); chk(2, 0, 1, 1, 2, 0, 0);
    sys_rst = 1;
    cyc(0, 0, 0, 0, 1, 0); chk(0, 1, 0, 0, 0, 0, 0);
    sys_rst = 0;
    cyc(0, 0, 0, 0, 0, 1); chk(0, 1, 0, 0, 0, 0, 0);

    @(negedge vga_clk); #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Match-level sequencer for the two-paddle VGA game. It decides when the paddles and ball are recentred, when the ball may move, and when the fast speed mode is active. It also keeps both scores and declares a winner. It sits between the debounced keys and ball-collision pulses on one side and the paddle/ball movers on the other, driving their recentre (guiwei), enable and speed-select (s) inputs.

Parameters:
WIN_SCORE, 7, points needed to win; 1 to 2^SCORE_W-1
SCORE_W, 4, score counter width
SERVE_FRAMES, 60, frames held in SERVE before play starts; at least 1
POINT_FRAMES, 30, frames held in POINT after a score; at least 1
SPEEDUP_HITS, 4, paddle hits in one rally before s asserts; at least 1
HIT_W, 3, hit counter width; 2^HIT_W-1 must be at least SPEEDUP_HITS

Ports:
vga_clk  in  1  pixel clock, sole clock
sys_rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start_p  in  1  one-cycle start/restart pulse (debounced key)
pause_p  in  1  one-cycle pause-toggle pulse
hit_p  in  1  one-cycle pulse on a paddle-ball collision
miss_l  in  1  one-cycle pulse when the ball passes the left wall
miss_r  in  1  one-cycle pulse when the ball passes the right wall
guiwei  out  1  recentre paddles and ball (level)
ball_en  out  1  ball movement enable
s  out  1  speed select to movers; 1 = fast
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
winner  out  2  00 none, 01 left, 10 right
state_o  out  3  current state, for the HUD/debug

Behaviour:
- Single clock domain, vga_clk. Reset is synchronous and active-high on sys_rst. A reset asserted mid-game takes effect at the next edge, regardless of state.
- Reset values:
  - state IDLE, guiwei=1, ball_en=0, s=0.
  - score_l=0, score_r=0, winner=00.
  - frame counter 0, hit counter 0.
- Outputs are registered and update on the same edge as the state register, so there is zero skew between state_o and the outputs.
  - guiwei=1 in IDLE, SERVE, POINT and OVER; 0 in PLAY and PAUSE.
  - ball_en=1 only in PLAY.
- States: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.
- IDLE:
  - start_p -> SERVE. Scores cleared, winner=00, frame counter=0, hit counter=0.
- SERVE:
  - Counts frame_tick pulses.
  - On the frame_tick that arrives with count==SERVE_FRAMES-1 -> PLAY.
- PLAY:
  - hit_p increments the hit counter, saturating at SPEEDUP_HITS.
  - s=1 from the cycle after the counter reaches SPEEDUP_HITS.
  - miss_l alone: score_r+1. miss_r alone: score_l+1.
  - miss_l and miss_r in the same cycle: no score, go to POINT (replayed rally).
  - A miss and hit_p in the same cycle: the miss wins, the hit is dropped.
  - After a scoring miss, if the new score == WIN_SCORE -> OVER, winner=01 (left) or 10 (right). Otherwise -> POINT.
  - Entering POINT: frame counter=0, hit counter=0, s=0.
  - pause_p with no miss in the same cycle -> PAUSE. If a miss coincides, the miss takes priority and pause_p is dropped.
- PAUSE:
  - All outputs hold except ball_en=0.
  - pause_p -> PLAY. Misses and hits are ignored; s is retained.
- POINT:
  - On the frame_tick with count==POINT_FRAMES-1 -> SERVE, with frame counter=0.
- OVER:
  - Scores and winner hold. start_p -> SERVE with scores cleared and winner=00.
- Ignored inputs:
  - start_p is ignored in SERVE, PLAY, PAUSE and POINT.
  - pause_p is ignored outside PLAY and PAUSE.
  - miss_l, miss_r and hit_p are ignored outside PLAY.
- Scores never wrap, since OVER is entered at WIN_SCORE.
- The frame counter resets on every state entry and counts only frame_tick pulses.
- Unused state encodings 6 and 7 recover to IDLE on the next edge.

Decomposition:
- Package game_pkg holds the state encodings and the winner codes (W_NONE, W_LEFT, W_RIGHT).
- One sub-module, frame_timer: synchronous load/clear, counts frame_tick, and emits a one-cycle done pulse when the count reaches its terminal value. Instantiated once and shared by SERVE and POINT; the terminal value is muxed by state.
- All other logic stays in game_ctrl.

Test Plan:
Bench parameters for all scenarios: WIN_SCORE=3, SERVE_FRAMES=3, POINT_FRAMES=2, SPEEDUP_HITS=2.
1. Reset, then start_p, then 3 frame_ticks -> state_o goes 0->1->2 on the 3rd tick's edge; guiwei drops to 0 and ball_en rises to 1 on that same edge.
2. In PLAY: hit_p x2, then miss_r -> s=1 after the 2nd hit; on the miss score_l=1, state_o=4, s=0. After 2 frame_ticks state_o=1.
3. miss_l and miss_r together in PLAY -> both scores unchanged, state_o=4.
4. Right scores 3 times -> score_r=3, winner=10, state_o=5, guiwei=1. A later miss_l leaves scores unchanged. start_p -> scores 0, winner=00, state_o=1.
5. In PLAY: pause_p, then miss_l, then pause_p -> state_o goes 2->3->2, ball_en goes 1->0->1, and score_r is unchanged.
6. sys_rst during PLAY with score_l=2 and s=1 -> next edge: state_o=0, scores 0, s=0, guiwei=1, ball_en=0.
